// File: rtl/udc_rr_sched_pkg.sv
// Shared types and constants for the udc_rr_sched round-robin up/down counter scheduler.
package udc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_UP  = 7'b0111110;
  localparam logic [6:0] SEG_DN  = 7'b1011110;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  typedef logic req_idx_t;

  function automatic logic [1:0] idx2oh(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/udc_rr_sched_if.sv
// Requester/display bundle for udc_rr_sched; master = switch/button front end, slave = scheduler.
interface udc_rr_sched_if #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 3
);
  logic [1:0]       req;
  logic [1:0]       dir;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [6:0]       d7;
  logic             digit;

  modport master (
    output req, dir, len0, len1,
    input  gnt, busy, done, out, d7, digit
  );

  modport slave (
    input  req, dir, len0, len1,
    output gnt, busy, done, out, d7, digit
  );
endinterface

// File: rtl/udc_rr_sched_arb.sv
// Two-way round-robin picker: combinational winner from req and the registered priority pointer.
module udc_rr_arb
  import udc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic [1:0] req_i,
  input  logic     upd_i,
  input  req_idx_t served_i,
  output logic [1:0] gnt_o,
  output req_idx_t win_o
);

  // prio_q names the requester that wins a tie; the one just served loses the next tie.
  req_idx_t prio_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else if (upd_i) begin
      prio_q <= ~served_i;
    end
  end

  always_comb begin
    win_o = prio_q;
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   win_o = 1'b0;
      2'b10:   win_o = 1'b1;
      default: win_o = prio_q;
    endcase
    if (req_i != 2'b00) gnt_o = idx2oh(win_o);
  end

endmodule

// File: rtl/udc_rr_sched.sv
// Round-robin burst scheduler over a shared up/down counter with 7-segment direction glyph.
// Build option UDC_SAT_EN: counter saturates at the rails instead of wrapping.
module udc_rr_sched
  import udc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 3
) (
  input  logic clk,
  input  logic rst,
  udc_rr_sched_if.slave bus
);

  state_t           state_q;
  req_idx_t         idx_q;
  logic             dir_q;
  logic [LEN_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_q;
  logic [1:0]       gnt_q;
  logic             busy_q;
  logic             done_q;
  logic [6:0]       d7_q;
  logic             digit_q;

  logic [1:0]       arb_gnt;
  req_idx_t         arb_win;
  logic [LEN_W-1:0] len_sel;
  logic             dir_sel;
  logic [WIDTH-1:0] out_d;

  udc_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (bus.req),
    .upd_i    (state_q == DONE),
    .served_i (idx_q),
    .gnt_o    (arb_gnt),
    .win_o    (arb_win)
  );

  assign len_sel = arb_win ? bus.len1 : bus.len0;
  assign dir_sel = arb_win ? bus.dir[1] : bus.dir[0];

  always_comb begin
`ifdef UDC_SAT_EN
    if (dir_q) out_d = (out_q == '1) ? out_q : out_q + 1'b1;
    else       out_d = (out_q == '0) ? out_q : out_q - 1'b1;
`else
    out_d = dir_q ? out_q + 1'b1 : out_q - 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d7_q    <= SEG_OFF;
      digit_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req != 2'b00) begin
            idx_q  <= arb_win;
            dir_q  <= dir_sel;
            cnt_q  <= len_sel;
            gnt_q  <= arb_gnt;
            busy_q <= 1'b1;
            // A zero-length request skips RUN and completes immediately.
            if (len_sel != '0) begin
              state_q <= RUN;
              d7_q    <= dir_sel ? SEG_UP : SEG_DN;
              digit_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              d7_q    <= SEG_OFF;
              digit_q <= 1'b0;
            end
          end
        end
        RUN: begin
          out_q <= out_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            d7_q    <= SEG_OFF;
            digit_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          d7_q    <= SEG_OFF;
          digit_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out   = out_q;
  assign bus.d7    = d7_q;
  assign bus.digit = digit_q;

endmodule

// File: tb/tb_udc_rr_sched.sv
// Bench for udc_rr_sched: directed and random bursts checked against a burst-level reference model.
module tb_udc_rr_sched;

  localparam int MODV = 16;
  localparam int MAXV = 15;
  localparam logic [6:0] G_UP = 7'b0111110;
  localparam logic [6:0] G_DN = 7'b1011110;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_out  = 0;
  int   m_ptr  = 0;

  udc_rr_sched_if #(.WIDTH(4), .LEN_W(3)) bus ();

  udc_rr_sched #(.WIDTH(4), .LEN_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counter value after j steps of one burst, straight from the wrap/saturate rule.
  function automatic int exp_out(input int start, input int up, input int j);
`ifdef UDC_SAT_EN
    if (up != 0) return (start + j > MAXV) ? MAXV : start + j;
    else         return (start - j < 0) ? 0 : start - j;
`else
    return (((start + ((up != 0) ? j : -j)) % MODV) + MODV) % MODV;
`endif
  endfunction

  task automatic scramble_inputs();
    bus.req  = 2'($urandom_range(0, 3));
    bus.dir  = 2'($urandom_range(0, 3));
    bus.len0 = 3'($urandom_range(0, 7));
    bus.len1 = 3'($urandom_range(0, 7));
  endtask

  task automatic do_burst(input logic [1:0] rq, input logic [1:0] dv,
                          input int l0, input int l1, input bit scr);
    int win, n, up;
    logic [1:0] oh;
    logic [6:0] gly;
    bus.req  = rq;
    bus.dir  = dv;
    bus.len0 = 3'(l0);
    bus.len1 = 3'(l1);
    @(posedge clk); #1;
    if (rq == 2'b00) begin
      chk("idle_gnt", 32'(bus.gnt), 0);
      chk("idle_busy", 32'(bus.busy), 0);
      return;
    end
    win = (rq == 2'b01) ? 0 : (rq == 2'b10) ? 1 : m_ptr;
    n   = (win == 1) ? l1 : l0;
    up  = int'(dv[win]);
    oh  = (win == 1) ? 2'b10 : 2'b01;
    gly = (up != 0) ? G_UP : G_DN;
    chk("grant", 32'(bus.gnt), 32'(oh));
    chk("busy_grant", 32'(bus.busy), 1);
    chk("done_grant", 32'(bus.done), (n == 0) ? 1 : 0);
    chk("d7_grant", 32'(bus.d7), (n == 0) ? 0 : 32'(gly));
    chk("out_grant", 32'(bus.out), 32'(m_out));
    for (int j = 1; j <= n; j++) begin
      if (scr) scramble_inputs();
      @(posedge clk); #1;
      chk("out_step", 32'(bus.out), 32'(exp_out(m_out, up, j)));
      chk("gnt_hold", 32'(bus.gnt), 32'(oh));
      chk("done_step", 32'(bus.done), (j == n) ? 1 : 0);
      chk("d7_step", 32'(bus.d7), (j == n) ? 0 : 32'(gly));
      chk("digit_step", 32'(bus.digit), (j == n) ? 0 : 1);
    end
    m_out = exp_out(m_out, up, n);
    m_ptr = 1 - win;
    if (scr) scramble_inputs();
    @(posedge clk); #1;
    chk("gnt_release", 32'(bus.gnt), 0);
    chk("busy_release", 32'(bus.busy), 0);
    chk("done_release", 32'(bus.done), 0);
    chk("out_release", 32'(bus.out), 32'(m_out));
    chk("d7_release", 32'(bus.d7), 0);
  endtask

  initial begin
    bus.req = 2'b00; bus.dir = 2'b00; bus.len0 = 3'd0; bus.len1 = 3'd0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_d7", 32'(bus.d7), 0);
    chk("rst_digit", 32'(bus.digit), 0);
    rst = 1'b1;
    m_out = 0; m_ptr = 0;

    do_burst(2'b01, 2'b01, 3, 0, 1'b0);
    do_burst(2'b01, 2'b01, 7, 0, 1'b0);
    do_burst(2'b01, 2'b01, 4, 0, 1'b0);
    chk("reach_14", 32'(bus.out), 14);
    do_burst(2'b10, 2'b10, 0, 4, 1'b0);

    for (int k = 0; k < 4; k++) do_burst(2'b11, 2'b10, 1, 1, 1'b0);

    do_burst(2'b01, 2'b01, 0, 5, 1'b0);
    do_burst(2'b10, 2'b00, 2, 6, 1'b1);
    do_burst(2'b01, 2'b01, 5, 1, 1'b1);

    for (int k = 0; k < 40; k++)
      do_burst(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)));

    // Mid-burst reset: bring counter to 5, start a 5-step down burst, reset after 2 steps.
    rst = 1'b0; bus.req = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1; m_out = 0; m_ptr = 0;
    do_burst(2'b01, 2'b01, 5, 0, 1'b0);
    chk("pre_cut_out", 32'(bus.out), 5);
    bus.req = 2'b01; bus.dir = 2'b00; bus.len0 = 3'd5;
    @(posedge clk); #1;
    chk("cut_grant", 32'(bus.gnt), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("cut_out", 32'(bus.out), 3);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("cut_out0", 32'(bus.out), 0);
    chk("cut_gnt", 32'(bus.gnt), 0);
    chk("cut_busy", 32'(bus.busy), 0);
    chk("cut_done", 32'(bus.done), 0);
    chk("cut_d7", 32'(bus.d7), 0);
    rst = 1'b1; bus.req = 2'b00;
    m_out = 0; m_ptr = 0;
    @(posedge clk); #1;
    chk("cut_no_done", 32'(bus.done), 0);
    bus.req = 2'b11;
    @(posedge clk); #1;
    chk("post_rst_tie", 32'(bus.gnt), 1);
    bus.req = 2'b00;
    repeat (10) @(posedge clk);
    #1;
    chk("final_idle", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
